calc_engine: RTL and testbench
==============================

// Module: calc_engine
// PURPOSE
//  Parametrised successor of the byte-entry calculator. A host writes operand bytes
//  and operator codes over a simple addressed write strobe, and the block folds them
//  into a DATA_W-bit accumulator: add, sub, and, or, xor, with signed overflow detect
//  and optional saturation. On "=" the result is latched and read back byte-serially,
//  MSB first, through a read_en/data_r_vld handshake. Everything runs in the clk domain.
// PARAMETERS
//  DATA_W   32  accumulator/operand width; must be a multiple of 8 and >= 8; NB = DATA_W/8
//  ADDR_W   7   width of addr
//  ADDR_NUM 1   address that receives operand bytes
//  ADDR_OP  2   address that receives operator codes
//  SAT_EN   0   1: add/sub saturate to signed max/min on overflow; 0: wrap
// PORTS
//  clk         in   1       system clock, rising edge
//  rst_n       in   1       reset, synchronous, active-low
//  write_vld   in   1       one-cycle write strobe; each high cycle is one write
//  addr        in   ADDR_W  write address, qualified by write_vld
//  data_w      in   8       write data (operand byte or operator code)
//  read_en     in   1       one-cycle request for the next result byte
//  data_r      out  8       result byte
//  data_r_vld  out  1       one-cycle pulse: data_r is valid
//  calc_done   out  1       result latched and readable
//  overflow    out  1       sticky signed overflow of the current calculation
//  err         out  1       sticky: operand too long or illegal opcode
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): acc=0, opnd=0, nbytes=0, pend_op=ADD, state=ACCUM.
//    All outputs are 0. Reset applies mid-calculation and mid-readout; readout is abandoned.
//  - Opcodes: 0x10 ADD, 0x20 SUB, 0x40 AND, 0x50 OR, 0x60 XOR, 0x30 EQUALS, 0x00 CLEAR.
//    Any other code sets err; the code is otherwise ignored.
//  - Writes to addresses other than ADDR_NUM and ADDR_OP are ignored.
//  - State ACCUM, write to ADDR_NUM:
//    - nbytes < NB: opnd <= {opnd[DATA_W-9:0], data_w}; nbytes++.
//    - nbytes == NB: the byte is dropped and err <= 1.
//  - State ACCUM, write of an operator (not CLEAR):
//    - nbytes > 0: acc <= acc <pend_op> opnd; then opnd <= 0, nbytes <= 0.
//    - nbytes == 0: no arithmetic; the new code replaces pend_op (operator overwrite).
//    - Non-EQUALS codes: pend_op <= code.
//  - Arithmetic is DATA_W-bit two's complement, single-cycle; acc is updated on the strobe edge.
//    - Signed overflow on ADD/SUB sets overflow (sticky).
//    - With SAT_EN=1, the stored value clamps to 0x7F..F or 0x80..0.
//    - Logic ops never set overflow.
//  - EQUALS: apply as above, then result <= updated acc, calc_done <= 1 (the edge after
//    the strobe), rd_ptr <= 0, state <= DONE. Internally acc <= 0, pend_op <= ADD.
//  - CLEAR (any state): acc, opnd, nbytes, overflow, err, calc_done, rd_ptr are cleared;
//    pend_op <= ADD; state <= ACCUM.
//  - State DONE:
//    - read_en: data_r <= result byte[rd_ptr] (MSB first) and data_r_vld=1 on the next edge.
//      rd_ptr wraps from NB-1 to 0, so the result can be re-read.
//    - Any write to ADDR_NUM/ADDR_OP: calc_done <= 0; overflow <= 0 and err <= 0; state <= ACCUM.
//      The write is then processed as in ACCUM on the same edge, starting a new calculation.
//    - write_vld and read_en in the same cycle: the write wins; no byte is output.
//  - read_en while in ACCUM: no data_r_vld; data_r holds its value.
//  - data_r holds its last value between reads. data_r_vld is never high for 2 consecutive
//    cycles unless read_en is.
// TESTING (DATA_W=32 unless noted)
//  1. num 00 00 01 00, op 10, num 00 00 00 2A, op 30, 4x read_en
//     -> calc_done=1; bytes 00 01 2A?? No: bytes 00,00,01,2A; overflow=0.
//  2. num 05, op 20, num 07, op 30
//     -> result FFFFFFFE, overflow=0; a 5th read_en returns FF (wrap to MSB).
//  3. num 7F FF FF FF, op 10, num 01, op 30
//     -> result 80000000, overflow=1. Same with SAT_EN=1 -> result 7FFFFFFF, overflow=1.
//  4. num 11 22 33 44 55, op 30 -> err=1, result 11223344.
//     op 10, op 20 (overwrite), num 03, op 30 after fresh start -> result FFFFFFFD.
//  5. After case 1 (DONE): write num 09 together with read_en, then op 30
//     -> no data_r_vld on the collision; calc_done falls, then rises; result 00000009.
//  6. rst_n=0 for 1 cycle after the 2nd readout byte
//     -> all outputs 0 next edge; a following read_en gives no data_r_vld.
//     DATA_W=8: num AB, op 50, num 0F, op 30 -> result AF.
```

Correction to test 1 (the inline "??" above is a typo): the four read_en pulses must return bytes 00, 00, 01, 2A.

Source files
------------

// File: rtl/calc_if.sv
// Host-side bus of the byte-entry calculator: addressed write strobe plus byte-serial readback.
interface calc_if #(
  parameter int ADDR_W = 7
);
  logic              write_vld;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data_w;
  logic              read_en;
  logic [7:0]        data_r;
  logic              data_r_vld;
  logic              calc_done;
  logic              overflow;
  logic              err;

  modport master (
    output write_vld, addr, data_w, read_en,
    input  data_r, data_r_vld, calc_done, overflow, err
  );

  modport slave (
    input  write_vld, addr, data_w, read_en,
    output data_r, data_r_vld, calc_done, overflow, err
  );
endinterface

// File: rtl/calc_engine.sv
// Byte-entry calculator: folds operand bytes into a DATA_W-bit accumulator with
// add/sub/and/or/xor, signed overflow detect, optional saturation and MSB-first readback.
module calc_engine #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 7,
  parameter int ADDR_NUM = 1,
  parameter int ADDR_OP  = 2,
  parameter int SAT_EN   = 0
) (
  input logic   clk,
  input logic   rst_n,
  calc_if.slave bus
);
  localparam int NB  = DATA_W / 8;
  localparam int NBW = $clog2(NB + 1);
  localparam int PW  = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [ADDR_W-1:0] A_NUM = ADDR_W'(ADDR_NUM);
  localparam logic [ADDR_W-1:0] A_OP  = ADDR_W'(ADDR_OP);
  localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic {S_ACCUM, S_DONE} state_e;
  typedef enum logic [7:0] {
    OP_CLR = 8'h00, OP_ADD = 8'h10, OP_SUB = 8'h20, OP_EQ = 8'h30,
    OP_AND = 8'h40, OP_OR  = 8'h50, OP_XOR = 8'h60
  } op_e;

  // Returns {signed_overflow, result}.
  function automatic logic [DATA_W:0] alu(input op_e op,
                                          input logic signed [DATA_W-1:0] a,
                                          input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] r;
    logic                     v;
    r = a;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        r = a + b;
        v = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        r = a - b;
        v = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = a;
    endcase
    return {v, r};
  endfunction

  // On overflow the true result carries the sign of the left operand.
  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [DATA_W-1:0] r,
                                                        input logic v,
                                                        input logic a_neg);
    if ((SAT_EN != 0) && v) return a_neg ? S_MIN : S_MAX;
    return r;
  endfunction

  state_e                   state_q, state_d;
  op_e                      pend_op_q, pend_op_d;
  logic signed [DATA_W-1:0] acc_q, acc_d;
  logic signed [DATA_W-1:0] opnd_q, opnd_d;
  logic [NBW-1:0]           nbytes_q, nbytes_d;
  logic [DATA_W-1:0]        result_q, result_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic                     calc_done_q, calc_done_d;
  logic                     ovf_q, ovf_d;
  logic                     err_q, err_d;
  logic [7:0]               data_r_q, data_r_d;
  logic                     data_r_vld_q, data_r_vld_d;

  logic [DATA_W:0]          alu_res;
  logic signed [DATA_W-1:0] acc_upd;
  logic                     ovf_upd;
  logic [DATA_W-1:0]        rd_word;
  int                       rd_shift;

  assign alu_res = alu(pend_op_q, acc_q, opnd_q);
  assign acc_upd = (nbytes_q != '0)
                   ? saturate(alu_res[DATA_W-1:0], alu_res[DATA_W], acc_q[DATA_W-1])
                   : acc_q;
  assign ovf_upd = (nbytes_q != '0) && alu_res[DATA_W];
  assign rd_shift = 8 * (NB - 1 - int'(rd_ptr_q));
  assign rd_word  = result_q >> rd_shift;

  always_comb begin
    state_d      = state_q;
    pend_op_d    = pend_op_q;
    acc_d        = acc_q;
    opnd_d       = opnd_q;
    nbytes_d     = nbytes_q;
    result_d     = result_q;
    rd_ptr_d     = rd_ptr_q;
    calc_done_d  = calc_done_q;
    ovf_d        = ovf_q;
    err_d        = err_q;
    data_r_d     = data_r_q;
    data_r_vld_d = 1'b0;

    if (bus.write_vld && ((bus.addr == A_NUM) || (bus.addr == A_OP))) begin
      // A write in DONE starts a fresh calculation and is then handled as in ACCUM.
      if (state_q == S_DONE) begin
        calc_done_d = 1'b0;
        ovf_d       = 1'b0;
        err_d       = 1'b0;
        state_d     = S_ACCUM;
      end
      if (bus.addr == A_NUM) begin
        if (int'(nbytes_q) < NB) begin
          opnd_d   = DATA_W'({opnd_q, bus.data_w});
          nbytes_d = nbytes_q + 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        case (bus.data_w)
          OP_CLR: begin
            acc_d       = '0;
            opnd_d      = '0;
            nbytes_d    = '0;
            ovf_d       = 1'b0;
            err_d       = 1'b0;
            calc_done_d = 1'b0;
            rd_ptr_d    = '0;
            pend_op_d   = OP_ADD;
            state_d     = S_ACCUM;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_EQ: begin
            acc_d    = acc_upd;
            opnd_d   = '0;
            nbytes_d = '0;
            if (ovf_upd) ovf_d = 1'b1;
            if (bus.data_w == OP_EQ) begin
              result_d    = acc_upd;
              calc_done_d = 1'b1;
              rd_ptr_d    = '0;
              state_d     = S_DONE;
              acc_d       = '0;
              pend_op_d   = OP_ADD;
            end else begin
              pend_op_d = op_e'(bus.data_w);
            end
          end
          default: err_d = 1'b1;
        endcase
      end
    end else if (bus.read_en && (state_q == S_DONE)) begin
      data_r_d     = rd_word[7:0];
      data_r_vld_d = 1'b1;
      rd_ptr_d     = (int'(rd_ptr_q) == NB - 1) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_ACCUM;
      pend_op_q    <= OP_ADD;
      acc_q        <= '0;
      opnd_q       <= '0;
      nbytes_q     <= '0;
      rd_ptr_q     <= '0;
      calc_done_q  <= 1'b0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
      data_r_q     <= '0;
      data_r_vld_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_op_q    <= pend_op_d;
      acc_q        <= acc_d;
      opnd_q       <= opnd_d;
      nbytes_q     <= nbytes_d;
      rd_ptr_q     <= rd_ptr_d;
      calc_done_q  <= calc_done_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
      data_r_q     <= data_r_d;
      data_r_vld_q <= data_r_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    result_q <= result_d;
  end

  assign bus.data_r     = data_r_q;
  assign bus.data_r_vld = data_r_vld_q;
  assign bus.calc_done  = calc_done_q;
  assign bus.overflow   = ovf_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_calc_engine.sv
// Scoreboard bench for calc_engine: wrapping 32-bit, saturating 32-bit and 8-bit instances.
module tb_calc_engine;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic       wv_a = 1'b0, re_a = 1'b0;
  logic [6:0] ad_a = '0;
  logic [7:0] dw_a = '0;
  logic       wv_b = 1'b0, re_b = 1'b0;
  logic [6:0] ad_b = '0;
  logic [7:0] dw_b = '0;

  calc_if #(.ADDR_W(7)) if0 ();
  calc_if #(.ADDR_W(7)) if1 ();
  calc_if #(.ADDR_W(7)) if2 ();

  assign if0.write_vld = wv_a; assign if0.addr = ad_a; assign if0.data_w = dw_a; assign if0.read_en = re_a;
  assign if1.write_vld = wv_a; assign if1.addr = ad_a; assign if1.data_w = dw_a; assign if1.read_en = re_a;
  assign if2.write_vld = wv_b; assign if2.addr = ad_b; assign if2.data_w = dw_b; assign if2.read_en = re_b;

  calc_engine #(.DATA_W(32), .SAT_EN(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  calc_engine #(.DATA_W(32), .SAT_EN(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  calc_engine #(.DATA_W(8),  .SAT_EN(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  always #5 clk = ~clk;

  logic [7:0] q0[$], q1[$], q2[$];
  int n_chk_d = 0, n_fail_d = 0;
  int n_chk_m = 0, n_fail_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk_d++;
    if (act !== exp) begin
      n_fail_d++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input bit tgt, input logic [6:0] a, input logic [7:0] d);
    if (!tgt) begin wv_a = 1'b1; ad_a = a; dw_a = d; end
    else      begin wv_b = 1'b1; ad_b = a; dw_b = d; end
    @(posedge clk); #1;
    wv_a = 1'b0; wv_b = 1'b0;
  endtask

  task automatic num(input bit tgt, input logic [7:0] d); wr(tgt, 7'd1, d); endtask
  task automatic op (input bit tgt, input logic [7:0] d); wr(tgt, 7'd2, d); endtask

  task automatic rd(input bit tgt);
    if (!tgt) re_a = 1'b1; else re_b = 1'b1;
    @(posedge clk); #1;
    re_a = 1'b0; re_b = 1'b0;
  endtask

  // Expected bytes for the wrapping (e0) and saturating (e1) 32-bit instances.
  task automatic rd_a(input logic [7:0] e0, input logic [7:0] e1);
    q0.push_back(e0);
    q1.push_back(e1);
    rd(1'b0);
  endtask

  task automatic rd_a4(input logic [31:0] w0, input logic [31:0] w1);
    for (int i = 3; i >= 0; i--) rd_a(w0[i*8 +: 8], w1[i*8 +: 8]);
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (if0.data_r_vld) begin
      n_chk_m++;
      if (q0.size() == 0) begin
        n_fail_m++; $display("FAIL u0_vld: got unexpected byte %h expected no data_r_vld", if0.data_r);
      end else begin
        e = q0.pop_front();
        if (if0.data_r !== e) begin n_fail_m++; $display("FAIL u0_byte: got %h expected %h", if0.data_r, e); end
      end
    end
    if (if1.data_r_vld) begin
      n_chk_m++;
      if (q1.size() == 0) begin
        n_fail_m++; $display("FAIL u1_vld: got unexpected byte %h expected no data_r_vld", if1.data_r);
      end else begin
        e = q1.pop_front();
        if (if1.data_r !== e) begin n_fail_m++; $display("FAIL u1_byte: got %h expected %h", if1.data_r, e); end
      end
    end
    if (if2.data_r_vld) begin
      n_chk_m++;
      if (q2.size() == 0) begin
        n_fail_m++; $display("FAIL u2_vld: got unexpected byte %h expected no data_r_vld", if2.data_r);
      end else begin
        e = q2.pop_front();
        if (if2.data_r !== e) begin n_fail_m++; $display("FAIL u2_byte: got %h expected %h", if2.data_r, e); end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_u0_outs", {if0.data_r, 4'd0, if0.data_r_vld, if0.calc_done, if0.overflow, if0.err}, 32'd0);
    chk("rst_u2_outs", {if2.data_r, 4'd0, if2.data_r_vld, if2.calc_done, if2.overflow, if2.err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 256 + 42
    num(0, 8'h00); num(0, 8'h00); num(0, 8'h01); num(0, 8'h00);
    op(0, 8'h10);
    num(0, 8'h2A);
    op(0, 8'h30);
    chk("t1_done", if0.calc_done, 1);
    chk("t1_ovf",  if0.overflow, 0);
    rd_a4(32'h0000012A, 32'h0000012A);

    // 5 - 7, then wrap of the read pointer
    num(0, 8'h05);
    chk("t2_done_fall", if0.calc_done, 0);
    op(0, 8'h20); num(0, 8'h07); op(0, 8'h30);
    chk("t2_done", if0.calc_done, 1);
    chk("t2_ovf",  if0.overflow, 0);
    rd_a4(32'hFFFFFFFE, 32'hFFFFFFFE);
    rd_a(8'hFF, 8'hFF);

    // Signed overflow: wrap vs saturate
    num(0, 8'h7F); num(0, 8'hFF); num(0, 8'hFF); num(0, 8'hFF);
    op(0, 8'h10); num(0, 8'h01); op(0, 8'h30);
    chk("t3_ovf_wrap", if0.overflow, 1);
    chk("t3_ovf_sat",  if1.overflow, 1);
    rd_a4(32'h80000000, 32'h7FFFFFFF);

    // Operand too long, then operator overwrite
    num(0, 8'h11); num(0, 8'h22); num(0, 8'h33); num(0, 8'h44);
    chk("t4_err_pre", if0.err, 0);
    num(0, 8'h55);
    chk("t4_err", if0.err, 1);
    op(0, 8'h30);
    chk("t4_err_hold", if0.err, 1);
    rd_a4(32'h11223344, 32'h11223344);
    op(0, 8'h10);
    chk("t4_err_clr", {if0.calc_done, if0.err}, 0);
    op(0, 8'h20); num(0, 8'h03); op(0, 8'h30);
    rd_a4(32'hFFFFFFFD, 32'hFFFFFFFD);

    // Write and read in the same cycle while DONE: the write wins
    wv_a = 1'b1; ad_a = 7'd1; dw_a = 8'h09; re_a = 1'b1;
    @(posedge clk); #1;
    wv_a = 1'b0; re_a = 1'b0;
    chk("t5_no_vld", if0.data_r_vld, 0);
    chk("t5_done_fall", if0.calc_done, 0);
    op(0, 8'h30);
    chk("t5_done_rise", if0.calc_done, 1);
    rd_a4(32'h00000009, 32'h00000009);

    // Reset in the middle of a readout
    num(0, 8'h12); num(0, 8'h34); num(0, 8'h56); num(0, 8'h78);
    op(0, 8'h30);
    rd_a(8'h12, 8'h12);
    rd_a(8'h34, 8'h34);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t6_u0_outs", {if0.data_r, 4'd0, if0.data_r_vld, if0.calc_done, if0.overflow, if0.err}, 32'd0);
    chk("t6_u1_outs", {if1.data_r, 4'd0, if1.data_r_vld, if1.calc_done, if1.overflow, if1.err}, 32'd0);
    rd(0);
    chk("t6_no_vld", {if0.data_r, 7'd0, if0.data_r_vld}, 0);

    // Ignored address, illegal opcode, CLEAR
    wr(0, 7'd5, 8'h99);
    chk("t7_ignored", {if0.calc_done, if0.err}, 0);
    op(0, 8'h77);
    chk("t7_illegal", if0.err, 1);
    op(0, 8'h00);
    chk("t7_clear", if0.err, 0);
    num(0, 8'h04); op(0, 8'h30);
    rd_a4(32'h00000004, 32'h00000004);

    // 8-bit instance: AB | 0F
    num(1, 8'hAB); op(1, 8'h50); num(1, 8'h0F); op(1, 8'h30);
    chk("t8_done", if2.calc_done, 1);
    q2.push_back(8'hAF); rd(1);
    q2.push_back(8'hAF); rd(1);

    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk_d + n_chk_m, n_fail_d + n_fail_m);
    $finish;
  end
endmodule
